// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// Used by mips_dmem_responder and dmem_array.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  // Word index of a byte address; the byte offset and all bits above the
  // array size are dropped, so out-of-range addresses alias.
  function automatic logic [31:0] dmem_index(input logic [31:0] addr,
                                             input int unsigned depth);
    return (addr >> 2) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array: clocked write and clocked read, no reset.
// Read-first: a write and a read to the same index in one cycle return the old word.
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Responder end of the MIPS data-memory port: one word load/store per request,
// held for LATENCY wait cycles. Define DMEM_ERR_EN to fault misaligned/out-of-range requests.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output dmem_state_t       dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends combinationally on ready on either channel.
  dmem_state_t       r_state;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rd_sel;
  logic              r_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_cur_write;
  logic [31:0]       w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic              w_fault;
  logic              w_we;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_accept     = (r_state == IDLE) && req_valid && r_req_ready;
  assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                        ((r_state == WAIT) && (r_cnt == LAT_W'(1)));

  // With zero latency the array is accessed on the accept edge itself, so
  // the request fields bypass the capture registers while in IDLE.
  assign w_cur_write = (r_state == IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_idx       = IDX_W'(dmem_index(w_cur_addr, DEPTH));

`ifdef DMEM_ERR_EN
  assign w_fault = (w_cur_addr[1:0] != 2'b00) ||
                   (w_cur_addr >= 32'(DEPTH * WORD_BYTES));
`else
  assign w_fault = 1'b0;
`endif

  assign w_we = w_enter_resp && w_cur_write && !w_fault;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (w_cur_wdata),
    .rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= LAT_W'(LATENCY);
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rd_sel    <= !req_write && !w_fault;
              r_err       <= w_fault;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - LAT_W'(1);
          if (r_cnt == LAT_W'(1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rd_sel    <= !r_write && !w_fault;
            r_err       <= w_fault;
          end
        end
        RESP: begin
          // The array index is frozen here, so its read port holds the word.
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rd_sel ? w_arr_rdata : '0;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule
